// File: rtl/mult_div_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
// Optional feature macro used by the unit: DIV_ZERO_TRAP_EN.
package mult_div_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Bits needed to hold values 0..value-1; bounded loop keeps it elaboration-safe.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_div_step.sv
// One iteration of the multiply/divide loop, purely combinational.
// mode=0: radix-2 shift-add multiply, acc = {partial_hi, multiplier}.
// mode=1: restoring divide, acc = {remainder, dividend/quotient}.
module mult_div_step #(
  parameter int WIDTH = 32
) (
  input  logic                 mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     mag,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  // Remainder never exceeds the divisor, so the W-bit modular difference is exact when it fits.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits     = (shifted >= {1'b0, mag});
    diff     = shifted[WIDTH-1:0] - mag;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (mode) begin
      if (fits) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Define DIV_ZERO_TRAP_EN to flag divide-by-zero via div_zero and leave HI/LO untouched.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = clog2(WIDTH + 1);

  state_t             state, state_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_q;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [CW-1:0]      cnt;
  logic               neg_lo_q, neg_hi_q;
  logic               is_div, is_signed, a_neg, b_neg, dz_now;
  logic [WIDTH-1:0]   abs_a, abs_b, quot, rem;
`ifdef DIV_ZERO_TRAP_EN
  logic               dz_q;
`endif

  // Operand conditioning for PREP and sign correction for FIN.
  always_comb begin
    is_div    = !(op_q == OP_MULT || op_q == OP_MULTU);
    is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    a_neg     = is_signed && a_q[WIDTH-1];
    b_neg     = is_signed && b_q[WIDTH-1];
    dz_now    = is_div && (b_q == '0);
    // A zero divisor runs the raw dividend through so HI ends up holding it unchanged.
    abs_a     = (a_neg && !dz_now) ? -a_q : a_q;
    abs_b     = b_neg ? -b_q : b_q;
    prod_fix  = neg_lo_q ? -acc : acc;
    quot      = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem       = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .mode     (is_div),
    .acc      (acc),
    .mag      (mag_q),
    .acc_next (acc_step)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; the counter reaching 1 marks the last iteration.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (cnt == CW'(1)) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_q    <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_wr) hi <= wdata;
          if (lo_wr) lo <= wdata;
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        PREP: begin
          mag_q    <= is_div ? abs_b : abs_a;
          acc      <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
          cnt      <= CW'(WIDTH);
          neg_lo_q <= (a_neg ^ b_neg) && !dz_now;
          neg_hi_q <= is_div && a_neg && !dz_now;
`ifdef DIV_ZERO_TRAP_EN
          dz_q     <= dz_now;
`endif
        end
        ITER: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
        end
        FIN: begin
          done <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
          if (dz_q) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quot;
          end else begin
            {hi, lo} <= prod_fix;
          end
`else
          if (is_div) begin
            hi <= rem;
            lo <= quot;
          end else begin
            {hi, lo} <= prod_fix;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + random bench for mult_div_unit with an expected-result queue.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_wr = 1'b0, lo_wr = 1'b0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] model_hi = '0, model_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.dz = d;
    return e;
  endfunction

  // Reference results from native 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    longint sx, sy, q, m;
    logic [63:0] p;
    r.dz = 1'b0; r.hi = model_hi; r.lo = model_lo;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == '0) begin
`ifdef DIV_ZERO_TRAP_EN
          r.dz = 1'b1;
`else
          r.lo = '1;
          r.hi = x;
`endif
        end else if (o == 2'b10) begin
          q = sx / sy; m = sx % sy;
          r.lo = q[31:0]; r.hi = m[31:0];
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  // Drive one start (optionally with MTHI+MTLO on the same edge) and queue its expectation.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit mt, input logic [W-1:0] wd, input exp_t e);
    sb.push_back(e);
    model_hi = e.hi; model_lo = e.lo;
    op = o; a = x; b = y; start = 1'b1; hi_wr = mt; lo_wr = mt; wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    op = ~o; a = ~x; b = ~y; wdata = ~wd;
  endtask

  // Wait (bounded) for done, check latency, then pop and compare the result.
  task automatic wait_done(input string tag, input int elapsed);
    exp_t e;
    int n;
    n = elapsed;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) check({tag, "_busy"}, {63'b0, busy}, 64'd1);
    end
    check({tag, "_latency"}, n, 35);
    if (done === 1'b1) begin
      check({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
      check({tag, "_queue"}, sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
        check({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
        check({tag, "_dz"}, {63'b0, div_zero}, {63'b0, e.dz});
      end
    end
  endtask

  task automatic no_done(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    exp_t e;
    logic [1:0] ro;
    logic [W-1:0] rx, ry, prev_hi;

    #3 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dz", {63'b0, div_zero}, 64'd0);
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MTHI / MTLO in idle
    hi_wr = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_wr = 1'b0;
    check("mthi_hi", {32'b0, hi}, 64'h1234);
    check("mthi_lo", {32'b0, lo}, 64'h0);
    lo_wr = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    lo_wr = 1'b0;
    check("mtlo_lo", {32'b0, lo}, 64'h5678);
    check("mtlo_hi", {32'b0, hi}, 64'h1234);
    model_hi = 32'h1234; model_lo = 32'h5678;

    // Test-plan directed ops, each started in the previous op's done cycle
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, mk(32'hFFFF_FFFE, 32'h0000_0001, 0));
    wait_done("multu_max", 0);
    launch(2'b00, 32'hFFFF_FFFD, 32'd7, 0, '0, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 0));
    wait_done("mult_neg", 0);
    launch(2'b10, 32'hFFFF_FFF9, 32'd2, 0, '0, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 0));
    wait_done("div_neg", 0);
    launch(2'b11, 32'd100, 32'd7, 0, '0, mk(32'd2, 32'd14, 0));
    wait_done("divu", 0);
    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, mk(32'h0, 32'h8000_0000, 0));
    wait_done("div_ovf", 0);
    launch(2'b10, 32'd7, 32'hFFFF_FFFE, 0, '0, mk(32'd1, 32'hFFFF_FFFD, 0));
    wait_done("div_negb", 0);
    launch(2'b00, 32'h8000_0000, 32'h8000_0000, 0, '0, mk(32'h4000_0000, 32'h0, 0));
    wait_done("mult_minmin", 0);
    launch(2'b11, 32'hFFFF_FFFF, 32'd10, 0, '0, mk(32'd5, 32'h1999_9999, 0));
    wait_done("divu_max", 0);

    // Divide by zero, with MTHI+MTLO on the start edge providing the prior HI/LO
    model_hi = 32'hCAFE_0001; model_lo = 32'hCAFE_0001;
`ifdef DIV_ZERO_TRAP_EN
    e = mk(32'hCAFE_0001, 32'hCAFE_0001, 1);
`else
    e = mk(32'd5, 32'hFFFF_FFFF, 0);
`endif
    launch(2'b10, 32'd5, 32'd0, 1, 32'hCAFE_0001, e);
    @(negedge clk);
    check("mt_on_start_hi", {32'b0, hi}, 64'hCAFE_0001);
    check("mt_on_start_lo", {32'b0, lo}, 64'hCAFE_0001);
    wait_done("div_zero", 1);

    // Random ops against the reference model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i % 2 == 1) ry = ry >> 20;
      e = model(ro, rx, ry);
      launch(ro, rx, ry, 0, '0, e);
      wait_done("random", 0);
    end

    // Start and MTHI while busy are both ignored
    prev_hi = model_hi;
    launch(2'b01, 32'h0001_0000, 32'h0001_0000, 0, '0, mk(32'h1, 32'h0, 0));
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_wr = 1'b0;
    check("busy_mthi_hi", {32'b0, hi}, {32'b0, prev_hi});
    wait_done("busy_start", 11);
    no_done("busy_start_extra", 45);

    // Reset in the middle of ITER
    launch(2'b00, 32'd5, 32'd5, 0, '0, mk(32'd0, 32'd25, 0));
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_hi", {32'b0, hi}, 64'd0);
    check("midrst_lo", {32'b0, lo}, 64'd0);
    void'(sb.pop_back());
    model_hi = '0; model_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    no_done("midrst_no_done", 45);
    check("midrst_hi_after", {32'b0, hi}, 64'd0);

    launch(2'b01, 32'd6, 32'd7, 0, '0, mk(32'd0, 32'd42, 0));
    wait_done("after_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
